icache_mem_arbiter: RTL
=======================

ICACHE_MEM_ARBITER -- requirements
Module: icache_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data word width; BLEN_WIDTH, 2, burst-length field width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pN_req (N=0,1)  in  1  single-cycle burst request pulse
- pN_addr  in  ADDR_WIDTH  block-aligned burst address, sampled with pN_req
- pN_burst_len  in  BLEN_WIDTH  beats minus one, sampled with pN_req
- pN_busy  out  1  request pending or burst in flight for port N
- pN_data  out  DATA_WIDTH  routed mem_data
- pN_valid  out  1  beat valid for port N
- pN_last  out  1  final beat for port N
- mem_req  out  1  burst request to memory
- mem_addr  out  ADDR_WIDTH  burst address
- mem_burst_len  out  BLEN_WIDTH  beats minus one
- mem_ready  in  1  memory accepts request while mem_req high
- mem_data  in  DATA_WIDTH  beat data
- mem_valid  in  1  beat valid
- mem_last  in  1  final beat

Function
REQ-003 Each port SHALL hold one pending slot {addr, len}; pN_req sets the slot on the next edge.
REQ-004 pN_req while port N's slot is already occupied SHALL be dropped; slot contents unchanged.
REQ-005 pN_req in the same cycle that port N's slot is issued SHALL be captured as a new pending request.
REQ-006 FSM states SHALL be IDLE, ISSUE, BURST.
REQ-007 IDLE: if any slot pending, select winner and go to ISSUE next cycle; else stay.
REQ-008 Arbitration SHALL be round-robin: the port not granted last wins a tie; a single pending port always wins.
REQ-009 ISSUE: mem_req=1, mem_addr/mem_burst_len from winner's slot; held stable until mem_ready sampled high; then clear winner's slot, go to BURST.
REQ-010 BURST: pW_data=mem_data, pW_valid=mem_valid, pW_last=mem_last for granted port W only; the other port's valid/last SHALL be 0.
REQ-011 mem_valid with mem_last in BURST SHALL return to IDLE and record W as last granted.
REQ-012 mem_valid outside BURST SHALL be ignored.
REQ-013 Idle-port latency: pN_req at cycle T SHALL produce mem_req at T+2 when FSM is in IDLE at T.
REQ-014 Back-to-back: after mem_last at cycle T, the next ISSUE SHALL begin at T+2.
REQ-015 pN_busy SHALL be 1 while port N's slot is occupied or port N is granted (ISSUE/BURST).
REQ-016 mem_req, mem_addr, mem_burst_len SHALL be 0 outside ISSUE.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, clear both slots, drive all outputs to 0, and set last-granted to port 1 (port 0 wins the first tie).
REQ-018 Reset mid-burst SHALL abandon the burst; beats arriving after release SHALL be ignored (FSM in IDLE).

Configuration
REQ-019 Macro ICACHE_ARB_PERF_EN defined SHALL add outputs perf_grant0, perf_grant1 (16-bit, per-port grants counted at mem_ready handshake) and perf_conflict (16-bit, IDLE cycles with both slots pending); all saturate at 0xFFFF and reset to 0.
REQ-020 Without ICACHE_ARB_PERF_EN these ports and counters SHALL not exist; remaining behaviour is identical.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE/ISSUE/BURST), port count constant (2) and the pending-slot struct {valid, addr, len}.
REQ-022 Round-robin winner selection SHALL be a sub-module rr_arb2 (inputs: two pending bits, last-granted; output: winner index, any-pending).

Verification
REQ-023 p0_req at T=10, addr 0x100, len 1; mem_ready=1 -> mem_req at T=12, mem_addr=0x100; two beats 0xA, 0xB routed to p0 with p0_last on 0xB; p1_valid stays 0.
REQ-024 p0_req and p1_req same cycle after reset -> port 0 granted first, port 1 issued 2 cycles after port 0's mem_last.
REQ-025 Third contention round after REQ-024 (both pulse again) -> port 0 granted (alternation), then port 1.
REQ-026 mem_ready held 0 for 5 cycles in ISSUE -> mem_req, mem_addr stable all 5 cycles; slot cleared only on handshake.
REQ-027 p1_req twice while p1 slot pending with addr 0x200 then 0x300 -> 0x300 dropped, issued addr 0x200.
REQ-028 rst_n low mid-BURST after first beat -> all outputs 0, busy 0; later mem_valid/mem_last ignored; new p1_req at 0x400 served normally.

Source files
------------

// File: rtl/icache_mem_arbiter_pkg.sv
// Shared types for the I-cache memory arbiter: FSM states, port count
// and the per-port pending-request slot.
package icache_mem_arbiter_pkg;

    localparam int NPORTS  = 2;
    localparam int SLOT_AW = 32;
    localparam int SLOT_LW = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BURST
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_LW-1:0] len;
    } slot_t;

endpackage

// File: rtl/icache_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] pend_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       any_o
);

    assign any_o = |pend_i;
    assign win_o = (&pend_i) ? ~last_i : pend_i[1];

endmodule

// File: rtl/icache_mem_arbiter.sv
// Two-port burst arbiter in front of the I-cache refill memory port.
// Define ICACHE_ARB_PERF_EN to add grant/conflict performance counters.
module icache_mem_arbiter
    import icache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLEN_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [BLEN_WIDTH-1:0] p0_burst_len,
    output logic                  p0_busy,
    output logic [DATA_WIDTH-1:0] p0_data,
    output logic                  p0_valid,
    output logic                  p0_last,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [BLEN_WIDTH-1:0] p1_burst_len,
    output logic                  p1_busy,
    output logic [DATA_WIDTH-1:0] p1_data,
    output logic                  p1_valid,
    output logic                  p1_last,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BLEN_WIDTH-1:0] mem_burst_len,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid,
    input  logic                  mem_last
`ifdef ICACHE_ARB_PERF_EN
    ,
    output logic [15:0]           perf_grant0,
    output logic [15:0]           perf_grant1,
    output logic [15:0]           perf_conflict
`endif
);

    state_e                state_q;
    logic                  grant_q;
    logic                  last_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [BLEN_WIDTH-1:0] mem_len_q;
    slot_t                 slot_q [NPORTS];

    logic [NPORTS-1:0]     req;
    logic [NPORTS-1:0]     pend;
    logic [NPORTS-1:0]     clr;
    logic [ADDR_WIDTH-1:0] addr [NPORTS];
    logic [BLEN_WIDTH-1:0] len  [NPORTS];
    logic                  win;
    logic                  any;
    logic                  hs;
    logic                  burst;

    assign req     = {p1_req, p0_req};
    assign addr[0] = p0_addr;
    assign addr[1] = p1_addr;
    assign len[0]  = p0_burst_len;
    assign len[1]  = p1_burst_len;
    assign pend    = {slot_q[1].valid, slot_q[0].valid};
    assign hs      = (state_q == ISSUE) && mem_ready;
    assign clr     = {hs & grant_q, hs & ~grant_q};

    rr_arb2 u_rr (
        .pend_i (pend),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any)
    );

    // A request landing on the handshake cycle refills the slot being freed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NPORTS; n++) slot_q[n] <= '0;
        end else begin
            for (int n = 0; n < NPORTS; n++) begin
                if (req[n] && (!slot_q[n].valid || clr[n])) begin
                    slot_q[n] <= '{1'b1, SLOT_AW'(addr[n]), SLOT_LW'(len[n])};
                end else if (clr[n]) begin
                    slot_q[n].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_len_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (any) begin
                    state_q    <= ISSUE;
                    grant_q    <= win;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= ADDR_WIDTH'(slot_q[win].addr);
                    mem_len_q  <= BLEN_WIDTH'(slot_q[win].len);
                end
                ISSUE: if (mem_ready) begin
                    state_q    <= BURST;
                    mem_req_q  <= 1'b0;
                    mem_addr_q <= '0;
                    mem_len_q  <= '0;
                end
                BURST: if (mem_valid && mem_last) begin
                    state_q <= IDLE;
                    last_q  <= grant_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign burst         = (state_q == BURST);
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_burst_len = mem_len_q;

    assign p0_valid = burst && !grant_q && mem_valid;
    assign p0_last  = burst && !grant_q && mem_valid && mem_last;
    assign p0_data  = (burst && !grant_q) ? mem_data : '0;
    assign p1_valid = burst && grant_q && mem_valid;
    assign p1_last  = burst && grant_q && mem_valid && mem_last;
    assign p1_data  = (burst && grant_q) ? mem_data : '0;

    assign p0_busy = pend[0] || ((state_q != IDLE) && !grant_q);
    assign p1_busy = pend[1] || ((state_q != IDLE) && grant_q);

`ifdef ICACHE_ARB_PERF_EN
    logic [15:0] pg0_q, pg1_q, pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pc_q  <= '0;
        end else begin
            if (hs && !grant_q && pg0_q != 16'hFFFF) pg0_q <= pg0_q + 16'd1;
            if (hs && grant_q && pg1_q != 16'hFFFF) pg1_q <= pg1_q + 16'd1;
            if (state_q == IDLE && &pend && pc_q != 16'hFFFF) pc_q <= pc_q + 16'd1;
        end
    end

    assign perf_grant0   = pg0_q;
    assign perf_grant1   = pg1_q;
    assign perf_conflict = pc_q;
`endif

endmodule
